// File: rtl/main_fsm_pkg.sv
// Shared definitions for the multicycle main controller: state encodings and
// the datapath selector codes that the control word drives.
package main_fsm_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        UNKNOWN = 4'd10
    } state_t;

    // ALU operand B select
    localparam logic [1:0] SRCB_WRITEDATA = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR      = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT     = 2'b00;
    localparam logic [1:0] RES_DATA       = 2'b01;
    localparam logic [1:0] RES_ALURESULT  = 2'b10;

endpackage

// File: rtl/main_fsm_outdec.sv
// Combinational state-to-control-word decode for the main controller.
// Any state value outside the encoded set yields an all-zero control word.
module main_fsm_outdec
    import main_fsm_pkg::*;
(
    input  logic [3:0] state,
    output logic       ir_write,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       alu_op,
    output logic       next_pc,
    output logic       reg_w,
    output logic       mem_w,
    output logic       branch,
    output logic       illegal
);

    always_comb begin
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_WRITEDATA;
        result_src = RES_ALUOUT;
        alu_op     = 1'b0;
        next_pc    = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            // Computing PC+4 again here makes R15 read as PC+8.
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            MEMADR: alu_src_b = SRCB_EXTIMM;
            MEMRD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
            end
            MEMWR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            EXECR:  alu_op = 1'b1;
            EXECI: begin
                alu_src_b = SRCB_EXTIMM;
                alu_op    = 1'b1;
            end
            ALUWB:  reg_w = 1'b1;
            BRANCH: begin
                alu_src_b  = SRCB_EXTIMM;
                result_src = RES_ALURESULT;
                branch     = 1'b1;
            end
            UNKNOWN: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Moore main controller for the multicycle processor: holds the state register
// and next-state logic; the control word comes from main_fsm_outdec.
module main_fsm
    import main_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t state;
    state_t next_state;

    // Only the I bit and the L/S bit steer the sequence.
    logic unused_funct_bits;
    assign unused_funct_bits = ^Funct[4:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH: next_state = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   next_state = Funct[5] ? EXECI : EXECR;
                    2'b01:   next_state = MEMADR;
                    2'b10:   next_state = BRANCH;
                    default: next_state = UNKNOWN;
                endcase
            end
            MEMADR:       next_state = Funct[0] ? MEMRD : MEMWR;
            MEMRD:        next_state = MEMWB;
            EXECR, EXECI: next_state = ALUWB;
            default:      next_state = FETCH;
        endcase
    end

    main_fsm_outdec u_outdec (
        .state      (state),
        .ir_write   (IRWrite),
        .adr_src    (AdrSrc),
        .alu_src_a  (ALUSrcA),
        .alu_src_b  (ALUSrcB),
        .result_src (ResultSrc),
        .alu_op     (ALUOp),
        .next_pc    (NextPC),
        .reg_w      (RegW),
        .mem_w      (MemW),
        .branch     (Branch),
        .illegal    (Illegal)
    );

    assign State = state;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: directed instructions, a mid-MEMRD async
// reset, then random instructions with garbage on Op/Funct outside DECODE/MEMADR.
module tb_main_fsm;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4;
    localparam int S_MEMWR = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9;
    localparam int S_UNKNOWN = 10;

    typedef int int_q[$];

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch, Illegal;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] State;

    int tests_run = 0;
    int failures  = 0;
    logic mon_en = 1'b0;
    logic [16:0] exp_q[$];

    main_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] observed();
        return {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                ALUOp, NextPC, RegW, MemW, Branch, Illegal};
    endfunction

    // Expected observation for a state, written straight from the per-state control table.
    function automatic logic [16:0] expected(int st);
        logic ir = 0, adr = 0, srca = 0, aluop = 0, npc = 0, regw = 0, memw = 0, br = 0, ill = 0;
        logic [1:0] srcb = 2'b00, res = 2'b00;
        case (st)
            S_FETCH:   begin ir = 1; npc = 1; srca = 1; srcb = 2'b10; res = 2'b10; end
            S_DECODE:  begin srca = 1; srcb = 2'b10; res = 2'b10; end
            S_MEMADR:  srcb = 2'b01;
            S_MEMRD:   adr = 1;
            S_MEMWB:   begin res = 2'b01; regw = 1; end
            S_MEMWR:   begin adr = 1; memw = 1; end
            S_EXECR:   aluop = 1;
            S_EXECI:   begin srcb = 2'b01; aluop = 1; end
            S_ALUWB:   regw = 1;
            S_BRANCH:  begin srcb = 2'b01; res = 2'b10; br = 1; end
            S_UNKNOWN: ill = 1;
            default: ;
        endcase
        return {4'(st), ir, adr, srca, srcb, res, aluop, npc, regw, memw, br, ill};
    endfunction

    // Instruction class determines the state walk.
    function automatic int_q build_seq(logic [1:0] op, logic [5:0] funct);
        int_q s;
        s.push_back(S_FETCH);
        s.push_back(S_DECODE);
        case (op)
            2'b01: begin
                s.push_back(S_MEMADR);
                if (funct[0]) begin s.push_back(S_MEMRD); s.push_back(S_MEMWB); end
                else          s.push_back(S_MEMWR);
            end
            2'b00: begin
                s.push_back(funct[5] ? S_EXECI : S_EXECR);
                s.push_back(S_ALUWB);
            end
            2'b10:   s.push_back(S_BRANCH);
            default: s.push_back(S_UNKNOWN);
        endcase
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Issue one instruction from FETCH; cut>0 stops inside the cut-th state without advancing.
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct, input int cut);
        int_q seq;
        int n;
        seq = build_seq(op, funct);
        n = (cut > 0 && cut < seq.size()) ? cut : seq.size();
        for (int i = 0; i < n; i++) exp_q.push_back(expected(seq[i]));
        for (int i = 0; i < n; i++) begin
            if (seq[i] == S_DECODE || seq[i] == S_MEMADR) {Op, Funct} = {op, funct};
            else                                          {Op, Funct} = 8'($urandom);
            if (cut == 0 || i < n - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    failures++;
                    $display("[TB] FAIL scoreboard_underflow at %0t: got state %0d, expected no output", $time, State);
                end else begin
                    checkOutput("cycle", 32'(observed()), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish by 200000");
        $fatal(1, "[TB] timeout");
    end

    initial begin : driver
        reset = 1'b1;
        Op    = 2'b00;
        Funct = 6'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_hold", 32'(observed()), 32'(expected(S_FETCH)));
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        applyStimulus(2'b01, 6'b000001, 0);
        applyStimulus(2'b01, 6'b000000, 0);
        applyStimulus(2'b00, 6'b101000, 0);
        applyStimulus(2'b00, 6'b001000, 0);
        applyStimulus(2'b10, 6'($urandom), 0);
        applyStimulus(2'b11, 6'($urandom), 0);

        // Abandon a load while in MEMRD; no write-back may follow.
        applyStimulus(2'b01, 6'b000001, 4);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        checkOutput("async_reset_midmemrd", 32'(observed()), 32'(expected(S_FETCH)));
        @(negedge clk);
        checkOutput("reset_held_after_edge", 32'(observed()), 32'(expected(S_FETCH)));
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        applyStimulus(2'b00, 6'b000000, 0);

        for (int k = 0; k < 150; k++)
            applyStimulus(2'($urandom_range(0, 3)), 6'($urandom), 0);

        mon_en = 1'b0;
        @(negedge clk);
        checkOutput("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
